ex_mem_stage_buf: RTL and testbench
===================================

// Module: ex_mem_stage_buf
// PURPOSE
//  Parametrised EX/MEM pipeline stage: registers the execute-stage control word and
//  data payload toward the memory stage. Adds valid/ready backpressure, an optional
//  2-entry skid buffer, and a flush that kills only control bits by default.
//  Sits between the ALU/branch unit and the data-memory interface; flush comes from
//  the branch/jump resolver.
// PARAMETERS
//  DATA_W      32  payload width (result, store data, next/jump address packed by caller)
//  CTRL_W      16  control width (RegWrite, MemWrite, MemRead, MemtoReg, funct3, rd, ...)
//  SKID        1   1: 2-entry skid buffer, registered in_ready; 0: single register
//  CLEAR_DATA  0   1: flush/reset also zero stored data; 0: data kept, ctrl zeroed
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       synchronous reset, active-high
//  flush      in   1       kill all held entries and this cycle's input beat
//  in_valid   in   1       EX beat valid
//  in_ready   out  1       stage accepts beat; in_fire = in_valid & in_ready
//  in_ctrl    in   CTRL_W  EX control word
//  in_data    in   DATA_W  EX data payload
//  out_valid  out  1       MEM beat valid
//  out_ready  in   1       MEM accepts; out_fire = out_valid & out_ready
//  out_ctrl   out  CTRL_W  control to MEM; forced 0 when out_valid=0
//  out_data   out  DATA_W  data to MEM (main register)
//  occupancy  out  2       entries held (0..2; max 1 when SKID=0)
//  kill_cnt   out  8       saturating count of entries discarded by flush
// BEHAVIOUR
//  Reset (rst=1 at clk edge): state EMPTY; main/skid ctrl=0; data=0; kill_cnt=0.
//   While rst high: in_ready=0, out_valid=0, out_ctrl=0, occupancy=0. Entries in flight
//   at reset are dropped and not counted.
//  States: EMPTY(0), HOLD(1, main valid), FULL(2, main+skid; SKID=1 only).
//  out_valid = (state!=EMPTY); occupancy = state; latency in->out = 1 cycle.
//  in_ready: SKID=1 -> (state!=FULL), combinationally independent of out_ready.
//            SKID=0 -> (state==EMPTY) | out_ready.
//  Transitions (flush=0):
//   EMPTY: in_fire -> HOLD, main<=in.
//   HOLD : in_fire&out_fire -> HOLD, main<=in; in_fire&!out_fire -> FULL, skid<=in
//          (SKID=0: cannot occur); !in_fire&out_fire -> EMPTY; else hold.
//   FULL : out_fire -> HOLD, main<=skid; else hold (in_ready=0).
//  Held entries stable (ctrl and data) while out_valid & !out_ready.
//  Flush (priority over all but rst): next state EMPTY; main/skid ctrl<=0; data<=0
//   only if CLEAR_DATA=1. An out_fire in the flush cycle completes normally (MEM
//   consumed it). in_ready keeps its normal value; an in_fire beat is accepted and
//   discarded.
//  kill_cnt on flush: += occupancy - out_fire + in_fire (0..2); saturates at 255,
//   never wraps.
//  flush while EMPTY with no in_fire: no-op apart from ctrl clear; kill_cnt unchanged.
//  No combinational path in_valid->out_valid, or (SKID=1) out_ready->in_ready.
// TESTING
//  T1 rst 3 cycles, then 1 beat ctrl=16'h00A5 data=32'h1234 out_ready=1 -> next cycle
//     out_valid=1, out_ctrl=00A5, out_data=1234; then EMPTY, out_ctrl=0.
//  T2 SKID=1, out_ready=0, push A,B -> occupancy 2, in_ready=0, out_data=A held;
//     out_ready=1 -> A then B on consecutive cycles, no loss/duplication.
//  T3 FULL + flush with out_ready=1 -> A transfers, B dropped, kill_cnt=1, EMPTY next.
//  T4 HOLD, out_ready=0, flush with in_fire -> kill_cnt+=2, out_ctrl=0; CLEAR_DATA=0
//     out_data retains, CLEAR_DATA=1 out_data=0.
//  T5 300 flushes killing 1 entry each -> kill_cnt sticks at 255.
//  T6 Random valid/ready/flush 10k cycles vs scoreboard (SKID=0 and 1): order kept,
//     out_ctrl=0 whenever out_valid=0; rst mid-FULL -> EMPTY next cycle, kill_cnt=0.

Source files
------------

// File: rtl/ex_mem_stage_buf.sv
// rtl/ex_mem_stage_buf.sv - EX/MEM pipeline stage with valid/ready, optional skid entry and control-only flush
module ex_mem_stage_buf #(
    parameter int DATA_W     = 32,
    parameter int CTRL_W     = 16,
    parameter int SKID       = 1,
    parameter int CLEAR_DATA = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_flush,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [CTRL_W-1:0] i_in_ctrl,
    input  logic [DATA_W-1:0] i_in_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [CTRL_W-1:0] o_out_ctrl,
    output logic [DATA_W-1:0] o_out_data,
    output logic [1:0]        o_occupancy,
    output logic [7:0]        o_kill_cnt
);

    // State value doubles as the number of held entries.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [DATA_W-1:0] r_skid_data;
    logic [7:0]        r_kill_cnt;

    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_load_main_in;
    logic              w_load_main_skid;
    logic              w_load_skid;
    logic [1:0]        w_occ;
    logic [2:0]        w_kill_inc;
    logic [8:0]        w_kill_sum;
    logic [7:0]        w_kill_nxt;

    // Ready depends only on registered state (plus out_ready in the single-register build).
    always_comb begin
        w_in_ready = 1'b0;
        if (!i_rst) begin
            if (SKID != 0) begin
                w_in_ready = (r_state != ST_FULL);
            end else begin
                w_in_ready = (r_state == ST_EMPTY) || i_out_ready;
            end
        end
    end

    assign w_occ       = r_state;
    assign w_out_valid = !i_rst && (r_state != ST_EMPTY);
    assign w_in_fire   = i_in_valid && w_in_ready;
    assign w_out_fire  = w_out_valid && i_out_ready;

    assign o_in_ready  = w_in_ready;
    assign o_out_valid = w_out_valid;
    assign o_out_ctrl  = w_out_valid ? r_main_ctrl : '0;
    assign o_out_data  = r_main_data;
    assign o_occupancy = i_rst ? 2'd0 : w_occ;
    assign o_kill_cnt  = r_kill_cnt;

    // Entries lost to a flush: held ones not consumed this cycle plus the beat accepted now.
    assign w_kill_inc = {1'b0, w_occ} + {2'b00, w_in_fire} - {2'b00, w_out_fire};
    assign w_kill_sum = {1'b0, r_kill_cnt} + {6'd0, w_kill_inc};
    assign w_kill_nxt = w_kill_sum[8] ? 8'hFF : w_kill_sum[7:0];

    // Next-state and register-load decode; flush overrides every normal move.
    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_in_fire) begin
                    w_state_nxt    = ST_HOLD;
                    w_load_main_in = 1'b1;
                end
            end
            ST_HOLD: begin
                if (w_in_fire && w_out_fire) begin
                    w_load_main_in = 1'b1;
                end else if (w_in_fire && (SKID != 0)) begin
                    w_state_nxt = ST_FULL;
                    w_load_skid = 1'b1;
                end else if (w_out_fire) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_out_fire) begin
                    w_state_nxt      = ST_HOLD;
                    w_load_main_skid = 1'b1;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
        if (i_flush) begin
            w_state_nxt      = ST_EMPTY;
            w_load_main_in   = 1'b0;
            w_load_main_skid = 1'b0;
            w_load_skid      = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Main and skid payload registers; flush clears control, data only when CLEAR_DATA is set.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_main_ctrl <= '0;
            r_main_data <= '0;
            r_skid_ctrl <= '0;
            r_skid_data <= '0;
        end else if (i_flush) begin
            r_main_ctrl <= '0;
            r_skid_ctrl <= '0;
            if (CLEAR_DATA != 0) begin
                r_main_data <= '0;
                r_skid_data <= '0;
            end
        end else begin
            if (w_load_main_in) begin
                r_main_ctrl <= i_in_ctrl;
                r_main_data <= i_in_data;
            end else if (w_load_main_skid) begin
                r_main_ctrl <= r_skid_ctrl;
                r_main_data <= r_skid_data;
            end
            if (w_load_skid) begin
                r_skid_ctrl <= i_in_ctrl;
                r_skid_data <= i_in_data;
            end
        end
    end

    // Saturating count of entries discarded by flush.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_kill_cnt <= 8'd0;
        end else if (i_flush) begin
            r_kill_cnt <= w_kill_nxt;
        end
    end

endmodule

// File: tb/tb_ex_mem_stage_buf.sv
// tb/tb_ex_mem_stage_buf.sv - randomized and directed bench for ex_mem_stage_buf against a queue model
module tb_ex_mem_stage_buf;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_ctrl = '0;
    logic [31:0] in_data = '0;
    logic        out_ready = 1'b0;

    logic        a_rdy  [3];
    logic        a_vld  [3];
    logic [15:0] a_ctrl [3];
    logic [31:0] a_data [3];
    logic [1:0]  a_occ  [3];
    logic [7:0]  a_kill [3];

    int n_cmp = 0;
    int n_bad = 0;

    // Model state per instance: 0 = SKID1/CLR0, 1 = SKID1/CLR1, 2 = SKID0/CLR0
    logic [47:0] mq [3][$];
    int          m_kill [3];
    logic [31:0] m_data [3];
    bit          m_init = 0;

    always #5 clk = ~clk;

    ex_mem_stage_buf #(.DATA_W(32), .CTRL_W(16), .SKID(1), .CLEAR_DATA(0)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_in_valid(in_valid), .o_in_ready(a_rdy[0]),
        .i_in_ctrl(in_ctrl), .i_in_data(in_data), .o_out_valid(a_vld[0]), .i_out_ready(out_ready),
        .o_out_ctrl(a_ctrl[0]), .o_out_data(a_data[0]), .o_occupancy(a_occ[0]), .o_kill_cnt(a_kill[0]));

    ex_mem_stage_buf #(.DATA_W(32), .CTRL_W(16), .SKID(1), .CLEAR_DATA(1)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_in_valid(in_valid), .o_in_ready(a_rdy[1]),
        .i_in_ctrl(in_ctrl), .i_in_data(in_data), .o_out_valid(a_vld[1]), .i_out_ready(out_ready),
        .o_out_ctrl(a_ctrl[1]), .o_out_data(a_data[1]), .o_occupancy(a_occ[1]), .o_kill_cnt(a_kill[1]));

    ex_mem_stage_buf #(.DATA_W(32), .CTRL_W(16), .SKID(0), .CLEAR_DATA(0)) u_dut2 (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_in_valid(in_valid), .o_in_ready(a_rdy[2]),
        .i_in_ctrl(in_ctrl), .i_in_data(in_data), .o_out_valid(a_vld[2]), .i_out_ready(out_ready),
        .o_out_ctrl(a_ctrl[2]), .o_out_data(a_data[2]), .o_occupancy(a_occ[2]), .o_kill_cnt(a_kill[2]));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare every instance against the model, then advance the model by one clock.
    task automatic check_and_model();
        for (int i = 0; i < 3; i++) begin
            int  cap;
            bit  e_rdy, e_vld, inf, outf;
            int  kc;
            cap   = (i < 2) ? 2 : 1;
            e_rdy = rst ? 1'b0 : ((cap == 2) ? (mq[i].size() < 2) : (mq[i].size() == 0 || out_ready));
            e_vld = !rst && (mq[i].size() > 0);
            if (m_init) begin
                chk($sformatf("in_ready[%0d]", i), {63'd0, a_rdy[i]}, {63'd0, e_rdy});
                chk($sformatf("out_valid[%0d]", i), {63'd0, a_vld[i]}, {63'd0, e_vld});
                chk($sformatf("out_ctrl[%0d]", i), {48'd0, a_ctrl[i]}, e_vld ? {48'd0, mq[i][0][47:32]} : 64'd0);
                chk($sformatf("out_data[%0d]", i), {32'd0, a_data[i]}, {32'd0, m_data[i]});
                chk($sformatf("occupancy[%0d]", i), {62'd0, a_occ[i]}, rst ? 64'd0 : 64'(mq[i].size()));
                chk($sformatf("kill_cnt[%0d]", i), {56'd0, a_kill[i]}, 64'(m_kill[i]));
            end
            if (rst) begin
                mq[i].delete();
                m_kill[i] = 0;
                m_data[i] = '0;
            end else begin
                inf  = in_valid && e_rdy;
                outf = e_vld && out_ready;
                if (flush) begin
                    kc = mq[i].size() - int'(outf) + int'(inf);
                    m_kill[i] = (m_kill[i] + kc > 255) ? 255 : m_kill[i] + kc;
                    mq[i].delete();
                    if (i == 1) m_data[i] = '0;
                end else begin
                    if (outf) void'(mq[i].pop_front());
                    if (inf) mq[i].push_back({in_ctrl, in_data});
                    if (mq[i].size() > 0) m_data[i] = mq[i][0][31:0];
                end
            end
        end
        if (rst) m_init = 1;
    endtask

    task automatic step(input logic r, input logic f, input logic v,
                        input logic [15:0] c, input logic [31:0] d, input logic ordy);
        rst = r; flush = f; in_valid = v; in_ctrl = c; in_data = d; out_ready = ordy;
        @(negedge clk);
        check_and_model();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // T1: reset then a single beat straight through
        repeat (3) step(1, 0, 0, 16'h0, 32'h0, 0);
        step(0, 0, 1, 16'h00A5, 32'h0000_1234, 1);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t1_valid[%0d]", i), {63'd0, a_vld[i]}, 64'd1);
            chk($sformatf("t1_ctrl[%0d]", i), {48'd0, a_ctrl[i]}, 64'h00A5);
            chk($sformatf("t1_data[%0d]", i), {32'd0, a_data[i]}, 64'h1234);
        end
        step(0, 0, 0, 16'h0, 32'h0, 1);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t1_empty_valid[%0d]", i), {63'd0, a_vld[i]}, 64'd0);
            chk($sformatf("t1_empty_ctrl[%0d]", i), {48'd0, a_ctrl[i]}, 64'd0);
        end

        // T2: fill the skid buffer under backpressure, then drain
        step(0, 0, 1, 16'h0A01, 32'hAAAA_0001, 0);
        step(0, 0, 1, 16'h0B02, 32'hBBBB_0002, 0);
        chk("t2_occ", {62'd0, a_occ[0]}, 64'd2);
        chk("t2_rdy", {63'd0, a_rdy[0]}, 64'd0);
        chk("t2_hold_data", {32'd0, a_data[0]}, 64'hAAAA_0001);
        step(0, 0, 0, 16'h0, 32'h0, 1);
        chk("t2_second_data", {32'd0, a_data[0]}, 64'hBBBB_0002);
        chk("t2_second_occ", {62'd0, a_occ[0]}, 64'd1);
        step(0, 0, 0, 16'h0, 32'h0, 1);
        chk("t2_drained_occ", {62'd0, a_occ[0]}, 64'd0);

        // T3: flush while FULL with MEM ready: head transfers, skid entry killed
        step(0, 0, 1, 16'h0A03, 32'hAAAA_0003, 0);
        step(0, 0, 1, 16'h0B04, 32'hBBBB_0004, 0);
        step(0, 1, 0, 16'h0, 32'h0, 1);
        chk("t3_kill0", {56'd0, a_kill[0]}, 64'd1);
        chk("t3_kill1", {56'd0, a_kill[1]}, 64'd1);
        chk("t3_kill2", {56'd0, a_kill[2]}, 64'd0);
        chk("t3_occ0", {62'd0, a_occ[0]}, 64'd0);

        // T4: flush in HOLD with a beat accepted in the same cycle
        step(0, 0, 1, 16'h0C05, 32'h0000_C0DE, 0);
        step(0, 1, 1, 16'h0D06, 32'h0000_D00D, 0);
        chk("t4_kill0", {56'd0, a_kill[0]}, 64'd3);
        chk("t4_kill1", {56'd0, a_kill[1]}, 64'd3);
        chk("t4_kill2", {56'd0, a_kill[2]}, 64'd1);
        chk("t4_ctrl0", {48'd0, a_ctrl[0]}, 64'd0);
        chk("t4_data_keep", {32'd0, a_data[0]}, 64'h0000_C0DE);
        chk("t4_data_clear", {32'd0, a_data[1]}, 64'd0);

        // T5: kill counter saturation
        for (int k = 0; k < 300; k++) begin
            step(0, 0, 1, 16'(k), 32'(k), 0);
            step(0, 1, 0, 16'h0, 32'h0, 0);
        end
        for (int i = 0; i < 3; i++)
            chk($sformatf("t5_sat[%0d]", i), {56'd0, a_kill[i]}, 64'd255);

        // T6a: reset while FULL
        step(0, 0, 1, 16'h0E07, 32'hEEEE_0007, 0);
        step(0, 0, 1, 16'h0F08, 32'hFFFF_0008, 0);
        step(1, 0, 0, 16'h0, 32'h0, 0);
        step(0, 0, 0, 16'h0, 32'h0, 0);
        chk("t6_rst_occ", {62'd0, a_occ[0]}, 64'd0);
        chk("t6_rst_valid", {63'd0, a_vld[0]}, 64'd0);
        chk("t6_rst_kill", {56'd0, a_kill[0]}, 64'd0);

        // T6b: random traffic with varying ready bias
        for (int k = 0; k < 10000; k++) begin
            logic r, f, v, o;
            int   bias;
            bias = (k / 1000) % 3;
            r = ($urandom_range(0, 499) == 0);
            f = ($urandom_range(0, 15) == 0);
            v = ($urandom_range(0, 2) != 0);
            o = (bias == 0) ? ($urandom_range(0, 3) != 0) :
                (bias == 1) ? ($urandom_range(0, 3) == 0) : $urandom_range(0, 1) != 0;
            step(r, f, v, 16'($urandom), $urandom, o);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
